// File: rtl/fft16_bfly_sequencer.sv
// Frame sequencer for the 8-bit complex radix-2 butterfly: loads a 16-sample frame,
// issues the 8 (k, k+8) pairs, captures the results in place and streams them out.
module fft16_bfly_sequencer (
    input  logic        clock_c,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_last,
    output logic [15:0] bf_a,
    output logic [15:0] bf_b,
    output logic [2:0]  bf_tw,
    output logic        bf_en,
    output logic        bf_clr,
    input  logic [15:0] bf_o1,
    input  logic [15:0] bf_o2,
    output logic        busy
);

    localparam int unsigned DW      = 16;
    localparam int unsigned N       = 16;
    localparam int unsigned AW      = 4;
    localparam int unsigned TW      = 3;
    localparam int unsigned LAT     = 4;
    localparam int unsigned HALF    = N / 2;
    localparam int unsigned LAST_T  = HALF + LAT - 1;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_ISSUE  = 2'd1,
        S_FLUSH  = 2'd2,
        S_UNLOAD = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   buf_q [N];

    logic            ld_we;
    logic            cap_we;
    logic [AW-1:0]   cap_lo;
    logic [AW-1:0]   cap_hi;

    // Capture targets: sum goes to the lower half slot, difference to the upper one
    assign cap_lo = cnt_q - AW'(LAT);
    assign cap_hi = cnt_q + AW'(LAT);

    always_ff @(posedge clock_c or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ld_we     = 1'b0;
        cap_we    = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        bf_a      = '0;
        bf_b      = '0;
        bf_tw     = '0;
        bf_en     = 1'b0;
        bf_clr    = 1'b1;
        busy      = 1'b0;

        case (state_q)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ld_we = 1'b1;
                    cnt_d = cnt_q + AW'(1);
                    if (cnt_q == AW'(N - 1)) begin
                        cnt_d   = '0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                bf_en  = 1'b1;
                bf_clr = 1'b0;
                busy   = 1'b1;
                bf_a   = buf_q[cnt_q];
                bf_b   = buf_q[{1'b1, cnt_q[TW-1:0]}];
                bf_tw  = cnt_q[TW-1:0];
                cap_we = (cnt_q >= AW'(LAT));
                cnt_d  = cnt_q + AW'(1);
                if (cnt_q == AW'(HALF - 1)) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                bf_en  = 1'b1;
                bf_clr = 1'b0;
                busy   = 1'b1;
                cap_we = 1'b1;
                cnt_d  = cnt_q + AW'(1);
                if (cnt_q == AW'(LAST_T)) begin
                    cnt_d   = '0;
                    state_d = S_UNLOAD;
                end
            end
            S_UNLOAD: begin
                out_valid = 1'b1;
                out_data  = buf_q[cnt_q];
                out_last  = (cnt_q == AW'(N - 1));
                if (out_ready) begin
                    cnt_d = cnt_q + AW'(1);
                    if (cnt_q == AW'(N - 1)) begin
                        cnt_d   = '0;
                        state_d = S_LOAD;
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
                cnt_d   = '0;
            end
        endcase
    end

    // Frame buffer: sample loads and in-place butterfly captures never target the same word
    always_ff @(posedge clock_c or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (ld_we && (cnt_q == AW'(i))) begin
                    buf_q[i] <= in_data;
                end else if (cap_we && (cap_lo == AW'(i))) begin
                    buf_q[i] <= bf_o1;
                end else if (cap_we && (cap_hi == AW'(i))) begin
                    buf_q[i] <= bf_o2;
                end
            end
        end
    end

endmodule

// File: tb/tb_fft16_bfly_sequencer.sv
// Directed bench for fft16_bfly_sequencer with a behavioural 4-stage butterfly attached.
module tb_fft16_bfly_sequencer;

    logic        clock_c = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic [15:0] bf_a;
    logic [15:0] bf_b;
    logic [2:0]  bf_tw;
    logic        bf_en;
    logic        bf_clr;
    logic [15:0] bf_o1;
    logic [15:0] bf_o2;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [15:0] frame [16];
    logic [15:0] expv  [16];
    logic [15:0] got   [16];
    logic [31:0] pipe  [4];

    always #5 clock_c = ~clock_c;

    fft16_bfly_sequencer dut (
        .clock_c   (clock_c),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .bf_a      (bf_a),
        .bf_b      (bf_b),
        .bf_tw     (bf_tw),
        .bf_en     (bf_en),
        .bf_clr    (bf_clr),
        .bf_o1     (bf_o1),
        .bf_o2     (bf_o2),
        .busy      (busy)
    );

    // Q1.7 product keeps bits [14:7]
    function automatic logic [7:0] pmul(input logic [7:0] x, input logic [7:0] y);
        logic signed [15:0] p;
        p = $signed(x) * $signed(y);
        return p[14:7];
    endfunction

    // W^k = exp(-j*2*pi*k/16) scaled by 127, as {re, im}
    function automatic logic [15:0] twiddle(input logic [2:0] k);
        case (k)
            3'd0: return {8'sd127,  8'sd0};
            3'd1: return {8'sd117, -8'sd49};
            3'd2: return {8'sd90,  -8'sd90};
            3'd3: return {8'sd49,  -8'sd117};
            3'd4: return {8'sd0,   -8'sd127};
            3'd5: return {-8'sd49, -8'sd117};
            3'd6: return {-8'sd90, -8'sd90};
            default: return {-8'sd117, -8'sd49};
        endcase
    endfunction

    function automatic logic [31:0] bfly(input logic [15:0] a, input logic [15:0] b,
                                         input logic [2:0] k);
        logic [15:0] w;
        logic [7:0]  tr, ti;
        w  = twiddle(k);
        tr = pmul(b[15:8], w[15:8]) - pmul(b[7:0], w[7:0]);
        ti = pmul(b[15:8], w[7:0]) + pmul(b[7:0], w[15:8]);
        return {a[15:8] + tr, a[7:0] + ti, a[15:8] - tr, a[7:0] - ti};
    endfunction

    // Butterfly stand-in: 4 enabled cycles of latency, synchronous clear
    always @(posedge clock_c) begin
        if (bf_clr) begin
            for (int i = 0; i < 4; i++) pipe[i] <= '0;
        end else if (bf_en) begin
            pipe[0] <= bfly(bf_a, bf_b, bf_tw);
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign bf_o1 = pipe[3][31:16];
    assign bf_o2 = pipe[3][15:0];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_c);
        #1;
    endtask

    task automatic build_model();
        logic [31:0] r;
        for (int k = 0; k < 8; k++) begin
            r = bfly(frame[k], frame[k+8], 3'(k));
            expv[k]   = r[31:16];
            expv[k+8] = r[15:0];
        end
    endtask

    task automatic clear_vectors();
        for (int i = 0; i < 16; i++) begin
            frame[i] = '0;
            expv[i]  = '0;
        end
    endtask

    task automatic random_frame();
        for (int i = 0; i < 16; i++) frame[i] = 16'($urandom);
        build_model();
    endtask

    task automatic send_frame(input int stall_at);
        int n;
        for (int i = 0; i < 16; i++) begin
            if (i == stall_at) begin
                in_valid = 1'b0;
                repeat (5) begin
                    check("stall_in_ready", in_ready, 1);
                    tick();
                end
            end
            in_valid = 1'b1;
            in_data  = frame[i];
            n = 0;
            while (!in_ready && n < 100) begin
                tick();
                n++;
            end
            if (n >= 100) check("in_ready_timeout", in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic check_issue();
        for (int t = 0; t < 12; t++) begin
            check($sformatf("bf_en[t%0d]", t), bf_en, 1);
            check($sformatf("bf_clr[t%0d]", t), bf_clr, 0);
            check($sformatf("busy[t%0d]", t), busy, 1);
            check($sformatf("in_ready_busy[t%0d]", t), in_ready, 0);
            if (t < 8) begin
                check($sformatf("bf_tw[t%0d]", t), bf_tw, t);
                check($sformatf("bf_a[t%0d]", t), bf_a, frame[t]);
                check($sformatf("bf_b[t%0d]", t), bf_b, frame[t+8]);
            end else begin
                check($sformatf("flush_ops[t%0d]", t), {bf_a, bf_b, 13'(bf_tw)}, 0);
            end
            tick();
        end
        check("bf_en_after", bf_en, 0);
        check("bf_clr_after", bf_clr, 1);
        check("busy_after", busy, 0);
        check("out_valid_rise", out_valid, 1);
    endtask

    task automatic collect(input bit bp);
        int idx;
        int n;
        idx = 0;
        n   = 0;
        check("in_ready_unload", in_ready, 0);
        while (idx < 16 && n < 400) begin
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                got[idx] = out_data;
                check($sformatf("out_last[%0d]", idx), out_last, (idx == 15));
                idx++;
            end
            tick();
            n++;
        end
        out_ready = 1'b0;
        if (idx < 16) check("out_timeout", idx, 16);
        for (int j = 0; j < 16; j++) begin
            check($sformatf("out_data[%0d]", j), got[j], expv[j]);
        end
        check("back_to_load", in_ready, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out"}, {out_valid, out_last, out_data}, 0);
        check({tag, "_bf_ops"}, {bf_a, bf_b, 13'(bf_tw)}, 0);
        check({tag, "_bf_ctl"}, {bf_en, bf_clr, busy}, 3'b010);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) got[i] = '0;

        #1 reset_n = 1'b0;
        #1 check_reset_outputs("por");
        tick();
        tick();
        reset_n = 1'b1;

        // Impulse at index 0
        clear_vectors();
        frame[0] = 16'h4000;
        expv[0]  = 16'h4000;
        expv[8]  = 16'h4000;
        send_frame(-1);
        check_issue();
        collect(1'b0);

        // Sample at index 8 (W^0)
        clear_vectors();
        frame[8] = 16'h4000;
        expv[0]  = 16'h3F00;
        expv[8]  = 16'hC100;
        send_frame(-1);
        check_issue();
        collect(1'b0);

        // Sample at index 12 (W^4 = -j)
        clear_vectors();
        frame[12] = 16'h4000;
        expv[4]   = 16'h00C0;
        expv[12]  = 16'h0040;
        send_frame(-1);
        check_issue();
        collect(1'b0);

        // Asynchronous reset in the middle of UNLOAD
        random_frame();
        send_frame(-1);
        check_issue();
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
        check("pre_reset_valid", out_valid, 1);
        #3 reset_n = 1'b0;
        #1 check_reset_outputs("mid_unload");
        tick();
        reset_n = 1'b1;
        check("post_release_ready", in_ready, 1);
        random_frame();
        send_frame(7);
        check_issue();
        collect(1'b1);

        // Back-to-back random frames with backpressure and an input stall
        for (int f = 0; f < 3; f++) begin
            random_frame();
            send_frame(5);
            check_issue();
            collect(1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft16_bfly_sequencer.md
# fft16_bfly_sequencer

Frame sequencer that drives the existing 8-bit complex radix-2 butterfly stage (16-bit packed input, 3-bit twiddle index, enable, synchronous clear) and collects its results. It accepts a 16-sample complex frame over a valid/ready stream and stores it in place. It issues the 8 butterfly pairs (k, k+8) with twiddle index k, captures the butterfly outputs after the 4-enabled-cycle pipeline latency, and streams the 16 results out in natural order. It sits between the sample buffer/upstream stage and the butterfly instance, and owns every butterfly control input.

## Interface
- No parameters. Frame size is 16 and twiddle index width is 3; both are fixed by the butterfly.
- clock_c  in  1  single clock; all flops on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  input sample accepted when in_valid and in_ready are both high.
- in_data  in  16  {re[15:8], im[7:0]}, two's complement Q1.7.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  16  {re, im} result.
- out_last  out  1  high with result index 15.
- bf_a  out  16  butterfly operand a (butterfly i1).
- bf_b  out  16  butterfly operand b (butterfly i2).
- bf_tw  out  3  twiddle index (butterfly i3).
- bf_en  out  1  butterfly pipeline enable (butterfly i4).
- bf_clr  out  1  butterfly synchronous clear (butterfly i5).
- bf_o1  in  16  butterfly sum output a + W^k·b.
- bf_o2  in  16  butterfly difference output a − W^k·b.
- busy  out  1  high in ISSUE and FLUSH.

## Operation
- Storage: 16×16-bit register array buf[0..15], plus counter cnt[3:0].
- State LOAD (reset state):
  - in_ready=1.
  - Each accepted sample is written to buf[cnt] and cnt increments.
  - Acceptance at cnt=15 sets cnt=0 and moves to ISSUE.
- State ISSUE:
  - Lasts 8 cycles; cycle t=cnt=0..7.
  - bf_en=1, bf_clr=0, bf_a=buf[t], bf_b=buf[t+8], bf_tw=t.
  - After t=7, go to FLUSH with cnt continuing at 8.
- State FLUSH:
  - Cycles t=8..11.
  - bf_en=1, bf_clr=0, bf_a=bf_b=0, bf_tw=0.
  - After t=11, set cnt=0 and go to UNLOAD.
- Capture, in ISSUE and FLUSH, when t≥4:
  - At the clock edge ending cycle t, write bf_o1 to buf[t−4] and bf_o2 to buf[t+4].
  - This in-place write never overwrites a word that is still to be read: buf[j] and buf[j+8] are read at t=j and written at t=j+4.
- State UNLOAD:
  - out_valid=1, out_data=buf[cnt], out_last=(cnt==15).
  - cnt advances only when out_valid and out_ready are both high.
  - The handshake at cnt=15 sets cnt=0 and returns to LOAD.
- Outside ISSUE and FLUSH: bf_en=0, bf_clr=1, bf_a=bf_b=0, bf_tw=0. This holds the butterfly pipeline at zero between frames.
- Outside LOAD: in_ready=0. Input is not accepted during ISSUE, FLUSH or UNLOAD.
- Outside UNLOAD: out_valid=0, out_last=0, out_data=0.
- No arithmetic in this block. All results come from the butterfly:
  - Products of 8-bit signed values are taken as product bits [14:7].
  - Sums wrap modulo 2^8 per component.
  - The bench model must wrap the same way.

## Timing
- Reset (reset_n low, asynchronous), effective immediately with no clock required:
  - State=LOAD, cnt=0, buf contents cleared to 0.
  - Outputs: in_ready=1, out_valid=0, out_last=0, out_data=0, bf_en=0, bf_clr=1, bf_a=bf_b=0, bf_tw=0, busy=0.
- Reset mid-frame, in any state: the frame is discarded and the block restarts in LOAD with cnt=0.
- Release is synchronous: the first sample can be accepted at the first rising edge with reset_n high.
- The butterfly has 4 enabled cycles of latency. Its output during enabled cycle t reflects the operands issued in cycle t−4.
- bf_en never drops inside ISSUE/FLUSH, so no stall accounting is needed.
- Frame timing from the last input handshake: ISSUE starts on the next cycle and runs 12 cycles. out_valid first rises 12 cycles after ISSUE starts.
- Minimum frame period is 16 + 12 + 16 = 44 cycles.
- out_ready held low in UNLOAD: out_data, out_last and cnt hold; there is no timeout.
- in_valid held low in LOAD: the block waits indefinitely and a partial frame is retained.

## Test plan
- Reset value check: assert reset_n low mid-UNLOAD → all outputs take their reset values immediately. After release, in_ready=1 and a full new frame round-trips correctly.
- Impulse at buf[0]: input (64,0) at index 0, all others 0 → out[0]=0x4000, out[8]=0x4000, all other outputs 0, out_last only with index 15.
- Sample at index 8: input (64,0) at index 8, others 0 → out[0]=(63,0)=0x3F00, out[8]=(−63,0)=0xC100.
- Sample at index 12: input (64,0) at index 12, others 0 → out[4]=(0,−64)=0x00C0, out[12]=(0,64)=0x0040.
- Issue sequence check: with any frame loaded → in the 8 ISSUE cycles, bf_tw steps 0..7 and bf_b equals input[t+8]. bf_en is high for exactly 12 cycles and bf_clr is low for the same 12.
- Backpressure: toggle out_ready randomly, and stall in_valid mid-LOAD for 5 cycles → no sample is lost or duplicated, and the outputs match a bit-exact model across 3 back-to-back random frames.
